// File: rtl/dog_scan_ctrl_if.sv
// Handshake and line-buffer/window bundle for dog_scan_ctrl.
// master = scan controller, slave = source/datapath side.
interface dog_scan_ctrl_if #(
    parameter int CW = 10,
    parameter int RW = 9
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          busy;
    logic          lb_wr_en;
    logic          lb_pad;
    logic [CW-1:0] lb_wr_col;
    logic          lb_rot;
    logic          win_valid;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          border;
    logic          frame_done;

    modport master (
        input  start, in_valid, out_ready,
        output in_ready, busy, lb_wr_en, lb_pad, lb_wr_col, lb_rot,
        output win_valid, win_row, win_col, border, frame_done
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, busy, lb_wr_en, lb_pad, lb_wr_col, lb_rot,
        input  win_valid, win_row, win_col, border, frame_done
    );
endinterface

// File: rtl/dog_scan_ctrl.sv
// Raster-scan controller for the blur/DoG stage: line-buffer writes, pads, windows.
// Optional macro BORDER_SKIP_EN suppresses windows that touch the image edge.
module dog_scan_ctrl #(
    parameter int COLS = 640,
    parameter int ROWS = 480,
    parameter int KMAX = 7,
    parameter int CW   = 10,
    parameter int RW   = 9
) (
    input  logic             clk,
    input  logic             rst,
    dog_scan_ctrl_if.master  bus
);
    localparam int HALF = KMAX / 2;

    localparam logic [CW-1:0] C_COLS = CW'(COLS);
    localparam logic [CW-1:0] C_LAST = CW'(COLS + HALF - 1);
    localparam logic [CW-1:0] C_HALF = CW'(HALF);
    localparam logic [CW-1:0] C_LO   = CW'(2 * HALF);
    localparam logic [RW-1:0] R_ROWS = RW'(ROWS);
    localparam logic [RW-1:0] R_LSTD = RW'(ROWS - 1);
    localparam logic [RW-1:0] R_LSTP = RW'(ROWS + HALF - 1);
    localparam logic [RW-1:0] R_HALF = RW'(HALF);
    localparam logic [RW-1:0] R_LO   = RW'(2 * HALF);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_fin;

    logic          r_wr_en;
    logic          r_pad;
    logic [CW-1:0] r_wr_col;
    logic          r_rot;
    logic          r_win;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;
    logic          r_border;

    logic w_last_col;
    logic w_pad_pos;
    logic w_in_ready;
    logic w_step;
    logic w_win;
    logic w_border;
    logic w_emit;

    assign w_last_col = (r_col == C_LAST);
    assign w_pad_pos  = (r_col >= C_COLS) || (r_row >= R_ROWS);
    assign w_win      = w_step && (r_row >= R_HALF) && (r_col >= C_HALF);
    // Window centre is (r-HALF, c-HALF), so edge tests fold onto r/c directly.
    assign w_border   = (r_row < R_LO) || (r_row >= R_ROWS) ||
                        (r_col < C_LO) || (r_col >= C_COLS);
`ifdef BORDER_SKIP_EN
    assign w_emit = w_win && !w_border;
`else
    assign w_emit = w_win;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_step && w_last_col && r_row == R_LSTD) w_next = S_FLUSH;
            S_FLUSH: if (r_fin) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_step     = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_in_ready = !w_pad_pos && bus.out_ready;
                w_step     = w_pad_pos ? bus.out_ready
                                       : (bus.in_valid && w_in_ready);
            end
            S_FLUSH: w_step = bus.out_ready && !r_fin;
            default: ;
        endcase
        bus.in_ready   = w_in_ready;
        bus.busy       = (r_state != S_IDLE);
        bus.frame_done = (r_state == S_DONE);
    end

    // r_fin holds FLUSH one extra cycle so the last window drains before DONE.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE) begin
            r_row <= '0;
            r_col <= '0;
            r_fin <= 1'b0;
        end else if (w_step) begin
            r_col <= w_last_col ? '0 : r_col + 1'b1;
            if (w_last_col) r_row <= r_row + 1'b1;
            if (r_state == S_FLUSH && w_last_col && r_row == R_LSTP)
                r_fin <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_pad     <= 1'b0;
            r_wr_col  <= '0;
            r_rot     <= 1'b0;
            r_win     <= 1'b0;
            r_win_row <= '0;
            r_win_col <= '0;
            r_border  <= 1'b0;
        end else begin
            r_wr_en  <= w_step;
            r_pad    <= w_step && w_pad_pos;
            r_rot    <= w_step && w_last_col;
            r_win    <= w_emit;
            r_border <= w_emit && w_border;
            if (w_step) r_wr_col <= r_col;
            if (w_emit) begin
                r_win_row <= r_row - R_HALF;
                r_win_col <= r_col - C_HALF;
            end
        end
    end

    assign bus.lb_wr_en  = r_wr_en;
    assign bus.lb_pad    = r_pad;
    assign bus.lb_wr_col = r_wr_col;
    assign bus.lb_rot    = r_rot;
    assign bus.win_valid = r_win;
    assign bus.win_row   = r_win_row;
    assign bus.win_col   = r_win_col;
    assign bus.border    = r_border;
endmodule

// File: tb/tb_dog_scan_ctrl.sv
// Self-checking bench for dog_scan_ctrl at COLS=8, ROWS=6, KMAX=5.
// Step-index model predicts every output each cycle; frame totals are pinned.
module tb_dog_scan_ctrl;
    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int KMAX = 5;
    localparam int H    = KMAX / 2;
    localparam int SC   = COLS + H;
    localparam int TOT  = (ROWS + H) * SC;
`ifdef BORDER_SKIP_EN
    localparam int EXP_WIN = 8;
    localparam int WR0 = 2, WC0 = 2, WCN = 4, FIRST_STEP = 45;
`else
    localparam int EXP_WIN = 48;
    localparam int WR0 = 0, WC0 = 0, WCN = 8, FIRST_STEP = 23;
`endif
    localparam int P_IDLE = 0, P_SCAN = 1, P_TAIL = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dog_scan_ctrl_if #(.CW(4), .RW(4)) bus ();

    dog_scan_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .KMAX(KMAX), .CW(4), .RW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: phase plus number of steps taken; (r,c) = (k/SC, k%SC).
    int m_ph = P_IDLE;
    int m_k  = 0;
    bit e_wr, e_pad, e_rot, e_win, e_brd;
    int e_col, e_wrow, e_wcol;
    int mr, mc, mwr, mwc;
    bit mdata, mstep, mbrd, memit;

    always @(posedge clk) begin
        e_wr = 0; e_pad = 0; e_rot = 0; e_win = 0; e_brd = 0;
        if (rst) begin
            m_ph = P_IDLE; m_k = 0;
            e_col = 0; e_wrow = 0; e_wcol = 0;
        end else begin
            case (m_ph)
                P_IDLE: if (bus.start) begin m_ph = P_SCAN; m_k = 0; end
                P_SCAN: begin
                    mr = m_k / SC; mc = m_k % SC;
                    mdata = (mr < ROWS) && (mc < COLS);
                    mstep = mdata ? (bus.in_valid && bus.out_ready) : bus.out_ready;
                    if (mstep) begin
                        e_wr = 1; e_pad = !mdata; e_col = mc;
                        e_rot = (mc == SC - 1);
                        if (mr >= H && mc >= H) begin
                            mwr = mr - H; mwc = mc - H;
                            mbrd = mwr < H || mwr >= ROWS - H ||
                                   mwc < H || mwc >= COLS - H;
`ifdef BORDER_SKIP_EN
                            memit = !mbrd;
`else
                            memit = 1;
`endif
                            if (memit) begin
                                e_win = 1; e_brd = mbrd;
                                e_wrow = mwr; e_wcol = mwc;
                            end
                        end
                        m_k++;
                        if (m_k == TOT) m_ph = P_TAIL;
                    end
                end
                P_TAIL: m_ph = P_DONE;
                default: m_ph = P_IDLE;
            endcase
        end
    end

    // DUT-observed event tallies
    int cyc = 0, d_steps = 0, d_pad = 0, d_rot = 0, d_win = 0, d_done = 0;
    int last_wr_cyc = 0, done_cyc = 0;
    int dq[$];
    int wstep[$];
    int cr, cc;
    bit crdy;

    always @(negedge clk) begin
        cr = m_k / SC; cc = m_k % SC;
        crdy = (m_ph == P_SCAN) && cr < ROWS && cc < COLS && bus.out_ready;
        chk("in_ready",   bus.in_ready,   crdy);
        chk("busy",       bus.busy,       m_ph != P_IDLE);
        chk("frame_done", bus.frame_done, m_ph == P_DONE);
        chk("lb_wr_en",   bus.lb_wr_en,   e_wr);
        chk("lb_pad",     bus.lb_pad,     e_pad);
        chk("lb_rot",     bus.lb_rot,     e_rot);
        chk("win_valid",  bus.win_valid,  e_win);
        chk("border",     bus.border,     e_brd);
        chk("lb_wr_col",  bus.lb_wr_col,  e_col);
        chk("win_row",    bus.win_row,    e_wrow);
        chk("win_col",    bus.win_col,    e_wcol);
        cyc++;
        if (bus.lb_wr_en === 1'b1) begin d_steps++; last_wr_cyc = cyc; end
        if (bus.lb_pad === 1'b1) d_pad++;
        if (bus.lb_rot === 1'b1) d_rot++;
        if (bus.win_valid === 1'b1) begin
            d_win++;
            dq.push_back(int'(bus.win_row) * 256 + int'(bus.win_col));
            wstep.push_back(d_steps);
        end
        if (bus.frame_done === 1'b1) begin d_done++; done_cyc = cyc; end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int stall, input int mid_start, input int rst_at);
        int s_steps, s_pad, s_rot, s_win, s_done, n0, w;
        bit did_rst;
        s_steps = d_steps; s_pad = d_pad; s_rot = d_rot;
        s_win = d_win; s_done = d_done; n0 = dq.size();
        did_rst = 0;
        bus.start = 1; bus.in_valid = 1; bus.out_ready = 1;
        cycle();
        bus.start = 0;
        for (int n = 0; n < 5000 && m_ph != P_IDLE; n++) begin
            if (stall != 0) begin
                bus.in_valid  = ($urandom_range(0, 99) >= 30);
                bus.out_ready = ($urandom_range(0, 99) >= 30);
            end
            bus.start = (mid_start >= 0 && m_k == mid_start && m_ph == P_SCAN);
            if (rst_at >= 0 && m_k == rst_at && m_ph == P_SCAN) begin
                rst = 1;
                cycle();
                rst = 0;
                did_rst = 1;
                @(negedge clk);
                chk("rst_busy",  bus.busy,      0);
                chk("rst_wr_en", bus.lb_wr_en,  0);
                chk("rst_win",   bus.win_valid, 0);
                chk("rst_rot",   bus.lb_rot,    0);
                chk("rst_steps", d_steps - s_steps, rst_at);
            end else begin
                cycle();
            end
        end
        bus.start = 0; bus.in_valid = 1; bus.out_ready = 1;
        chk("frame_timeout", m_ph, P_IDLE);
        repeat (3) cycle();
        if (did_rst) begin
            chk("rst_no_done", d_done - s_done, 0);
            return;
        end
        chk("n_steps", d_steps - s_steps, TOT);
        chk("n_pad",   d_pad - s_pad, 32);
        chk("n_rot",   d_rot - s_rot, 8);
        chk("n_win",   d_win - s_win, EXP_WIN);
        chk("n_done",  d_done - s_done, 1);
        chk("done_lat", done_cyc - last_wr_cyc, 1);
        if (dq.size() >= n0 + EXP_WIN) begin
            chk("first_win_step", wstep[n0] - s_steps, FIRST_STEP);
            for (int i = 0; i < EXP_WIN; i++) begin
                w = (WR0 + i / WCN) * 256 + (WC0 + i % WCN);
                chk("win_order", dq[n0 + i], w);
            end
        end
    endtask

    initial begin
        bus.start = 0; bus.in_valid = 0; bus.out_ready = 0;
        rst = 1;
        repeat (3) cycle();
        rst = 0;
        @(negedge clk);
        chk("reset_busy",  bus.busy,      0);
        chk("reset_rdy",   bus.in_ready,  0);
        chk("reset_col",   bus.lb_wr_col, 0);
        chk("reset_wrow",  bus.win_row,   0);
        chk("reset_done",  bus.frame_done, 0);
        cycle();

        run_frame(0, -1, -1);
`ifndef BORDER_SKIP_EN
        chk("pin_first", dq[0], 0);
        chk("pin_last",  dq[47], 5 * 256 + 7);
        chk("pin_first_step", wstep[0], 23);
`endif

        bus.in_valid = 1; bus.out_ready = 1;
        begin
            int s;
            s = d_steps;
            repeat (5) cycle();
            @(negedge clk);
            chk("idle_in_valid", d_steps - s, 0);
        end
        cycle();

        run_frame(1, -1, -1);
        run_frame(0, 30, -1);
        run_frame(0, -1, 37);
        run_frame(0, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dog_scan_ctrl.md
# dog_scan_ctrl

Raster-scan controller for the Gaussian blur / difference-of-Gaussian stage of the SIFT pipeline. It accepts one pixel per handshake from the image source and drives the line-buffer write side, including synthetic border padding. It tells the blur/DoG datapath when a complete KMAX x KMAX window, centred on image pixel (win_row, win_col), is present, and it signals end of frame. One instance sequences the shared 3x3/5x5/7x7 blur bank and the signed DoG subtractors for one octave.

## Interface
- COLS, 640, image width in pixels
- ROWS, 480, image height in pixels
- KMAX, 7, largest blur kernel size (odd); HALF = KMAX/2
- CW, 10, column counter width; must hold COLS+HALF-1
- RW, 9, row counter width; must hold ROWS+HALF-1

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start pulse; ignored unless in IDLE
- in_valid  in  1  source pixel available
- in_ready  out  1  controller accepts the pixel this cycle
- out_ready  in  1  datapath/downstream can take a step
- busy  out  1  high in any state other than IDLE
- lb_wr_en  out  1  write the current pixel into the line buffer
- lb_pad  out  1  the write is a zero pad, not source data
- lb_wr_col  out  CW  line-buffer column address
- lb_rot  out  1  rotate the line-buffer rows (end of a scan row)
- win_valid  out  1  window centred at (win_row, win_col) is complete
- win_row  out  RW  centre row
- win_col  out  CW  centre column
- border  out  1  the window overlaps the image edge
- frame_done  out  1  one-cycle pulse after the last window

## Operation
- **Scan grid.** The scan covers (ROWS+HALF) rows x (COLS+HALF) steps.
  - Scan position (r, c) starts at (0, 0).
  - Positions with c>=COLS or r>=ROWS are pad steps. Pad steps consume no input.
- **States.**
  - IDLE: start moves to RUN.
  - RUN: entered from IDLE with r=c=0. After the last step of row ROWS-1, go to FLUSH.
  - FLUSH: runs the pad rows r in ROWS..ROWS+HALF-1. After the last pad step, go to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- **in_ready.** in_ready = (state==RUN) && c<COLS && out_ready. It is combinational.
- **Step condition.**
  - On a data position, a step occurs when in_valid && in_ready.
  - On a pad position, a step occurs when out_ready is high and the state is RUN or FLUSH.
  - No step means no counter movement and no output strobes.
- **Counter advance on each step.**
  - c increments.
  - When c==COLS+HALF-1: c wraps to 0, r increments, and lb_rot is asserted with that step.
- **Per-step outputs.**
  - lb_wr_en=1.
  - lb_pad = (c>=COLS || r>=ROWS).
  - lb_wr_col = c.
- **Window generation.**
  - A step emits a window when r>=HALF and c>=HALF.
  - win_row = r-HALF and win_col = c-HALF. No negative values occur.
  - Each frame produces exactly ROWS*COLS windows, in raster order.
- **Border flag.** border = win_row<HALF || win_row>=ROWS-HALF || win_col<HALF || win_col>=COLS-HALF.
- **Boundary conditions.**
  - A start pulse while busy is ignored.
  - in_valid in IDLE, FLUSH or DONE is ignored (in_ready=0).
  - rst mid-frame returns to IDLE, clears r and c, and drops every strobe on the next edge. No frame_done is issued.
  - If out_ready deasserts mid-row, the position is held indefinitely.

## Timing
- **Reset values.** All outputs are 0 after reset:
  - in_ready, busy, lb_wr_en, lb_pad, lb_rot, win_valid, border, frame_done
  - lb_wr_col, win_row, win_col
- **Latency.**
  - in_ready is combinational, so it depends on the current-cycle out_ready.
  - All lb_* and win_* outputs are registered. They appear in the cycle after the step and are held for exactly one cycle.
  - The address outputs hold their last values when no strobe is active.
- **Start.** RUN is entered on the edge after start. in_ready can rise in the first RUN cycle.
- **Frame end.**
  - frame_done is asserted in the DONE cycle. That is the cycle after the final registered win_valid, i.e. 2 cycles after the last step.
  - busy falls in the cycle after DONE.
- **Throughput.** With in_valid and out_ready held high, one step per cycle. A frame then takes (ROWS+HALF)*(COLS+HALF) step cycles plus 3 cycles of overhead.

## Configuration
- **BORDER_SKIP_EN**, defined:
  - win_valid is suppressed whenever border=1.
  - A frame emits (ROWS-2*HALF)*(COLS-2*HALF) windows.
  - Line-buffer writes and the scan are unchanged.
- **Undefined (default):** every window is emitted with the border flag, ROWS*COLS windows per frame.

## Test plan
All scenarios use COLS=8, ROWS=6, KMAX=5 (HALF=2).
- Reset, then a start pulse with in_valid=out_ready=1 held:
  - 80 steps.
  - 48 win_valid pulses; the first is (0,0) in the cycle after step 23 (r=2, c=2); the last is (5,7).
  - lb_rot 8 times.
  - frame_done exactly once, 2 cycles after the final step.
- Random in_valid/out_ready stalls (30% low) -> windows are identical to the unstalled run, in order. No step occurs while out_ready=0.
- Pad check -> lb_pad=1 exactly on the 32 steps with c>=8 or r>=6. in_ready=0 on every one of those steps.
- rst asserted at step 37 -> the next cycle has busy=0 and all strobes at 0. A new start repeats scenario 1 exactly.
- start pulsed mid-frame and in_valid pulsed in IDLE -> no effect. Window count stays 48.
- With BORDER_SKIP_EN defined -> 8 windows: rows 2..3, columns 2..5. border=0 on all of them.
